turbosound_n: RTL and testbench
===============================

// Module: turbosound_n
// PURPOSE
//  Parametrised N-chip Turbosound controller: decodes the AY-style BDIR/BC/DI bus into select/write strobes
//  for NUM_CHIPS external jt03 (YM2203) instances and mixes their PSG and FM outputs into stereo.
//  Successor of the 2-chip Turbosound-FM glue. Adds a chip-page register (up to 8 chips), a parameter-selected
//  pan mode, and a sequential one-chip-per-cycle mixer started by a sample strobe.
// PARAMETERS
//  NUM_CHIPS   2   chips served, 1..8
//  PSG_W       8   width of each PSG channel output (unsigned)
//  FM_W        16  width of each FM output (signed)
//  OUT_W       12  width of CHANNEL_L/R (signed)
//  PAN_MODE    0   0=ABC (L=2A+B, R=2C+B), 1=ACB (L=2A+C, R=2B+C), 2=mono (both = A+B+C)
// PORTS
//  CLK         in   1                 global clock
//  RESET       in   1                 asynchronous, active-high reset
//  BDIR        in   1                 bus direction (1=write)
//  BC          in   1                 bus control (1=address phase)
//  DI          in   8                 bus data in
//  DO          out  8                 read data of selected chip
//  CHIP_DIN    out  8                 latched data to all chips
//  CHIP_ADDR   out  1                 jt03 addr pin
//  CHIP_CS_N   out  NUM_CHIPS         one-hot-low chip select
//  CHIP_WR_N   out  1                 write strobe, low 1 cycle
//  CHIP_DOUT   in   8*NUM_CHIPS       per-chip read data, chip i at [8i+:8]
//  PSG_A/B/C   in   PSG_W*NUM_CHIPS   per-chip PSG channels
//  FM_SND      in   FM_W*NUM_CHIPS    per-chip FM output
//  SAMPLE_STB  in   1                 start one mix pass
//  CHANNEL_L/R out  OUT_W             mixed stereo sample
//  OUT_VALID   out  1                 1-cycle pulse when CHANNEL_L/R update
// BEHAVIOUR
//  - RESET, BDIR, BC and DI pass through a 2-flop synchroniser; all decoding uses the synchronised copies.
//  - Reset values: sel=1 (chip 1, or 0 if NUM_CHIPS=1), stat_sel=1, fm_ena=0, acc=0, wr pulse 0, CHIP_WR_N=1.
//    Also CHANNEL_L/R=0, OUT_VALID=0, mixer IDLE.
//  - Decode is evaluated on each synchronised BDIR rising edge:
//    - BC=1, DI[7:3]=11111: sel[0]=DI[0], stat_sel=DI[1], fm_ena=~DI[2], acc=0.
//    - BC=1, DI[7:3]=11110: sel[2:1]=DI[1:0], acc=0.
//    - Other BC=1: acc = wr = (DI[7:4]==0) | fm_ena.
//    - BC=0: wr=acc.
//    - DI is latched into CHIP_DIN on every such edge.
//  - Chip write: wr is a 1-cycle pulse in the cycle after the edge. CHIP_WR_N = ~wr.
//  - CHIP_ADDR = (BDIR|wr) ? ~BC : stat_sel, all from synchronised signals.
//  - Chip select: CHIP_CS_N[i] = (sel!=i). If sel>=NUM_CHIPS, all CS_N are high and DO=8'hFF.
//    Otherwise DO = CHIP_DOUT of chip sel.
//  - Mixer FSM IDLE -> ACC -> OUT -> IDLE:
//    - IDLE, SAMPLE_STB=1: clear accumulators, idx=0.
//    - ACC: add chip idx each cycle, idx++. Leave ACC after idx = NUM_CHIPS-1.
//    - OUT: register CHANNEL_L/R and pulse OUT_VALID.
//    - Latency: SAMPLE_STB at cycle t gives OUT_VALID at t+NUM_CHIPS+1.
//  - SAMPLE_STB outside IDLE is dropped and does not queue.
//  - Arithmetic:
//    - Per-channel PSG sum uses PSG_W+3 bits, then saturates to 2^PSG_W-1.
//    - Pan terms are zero-extended; the "2x" term is a left shift by 1.
//    - FM: accumulate FM_SND[FM_W-1 -: OUT_W-2] sign-extended to OUT_W.
//    - Final L/R = pan + (fm_ena ? fm_sum : 0), wrapping mod 2^OUT_W (matches legacy).
//  - RESET asserted mid-pass: FSM returns to IDLE, partial sums are discarded, and no OUT_VALID is issued.
//  - fm_ena changing mid-pass takes effect at OUT.
// STRUCTURE
//  - turbosound_pkg holds: CTL_SEL byte prefix 5'b11111, CTL_PAGE prefix 5'b11110, pan_mode_e enum, mix_state_e enum.
//  - Sub-module ts_bus_decode holds the synchroniser, decode, select/addr/wr logic and DO mux.
//  - The mixer FSM lives in turbosound_n.
// TESTING
//  - Reset, then BC write 0x07 with BDIR rising, then data write 0x55:
//    CHIP_ADDR=0 and CHIP_WR_N low 1 cycle with CHIP_DIN=0x07; then CHIP_ADDR=1 with CHIP_DIN=0x55.
//    CHIP_CS_N=2'b01.
//  - NUM_CHIPS=4, write 0xF1 then 0xFE:
//    sel=2 (0xF1 sets sel[2:1]=01, 0xFE sets sel[0]=0). CHIP_CS_N=4'b1011, fm_ena=0 (DI[2]=1), stat_sel=1.
//    DO = CHIP_DOUT[23:16].
//  - With fm_ena=0, write reg 0x30 (address phase): no CHIP_WR_N pulse. Following data write: no pulse.
//  - NUM_CHIPS=2, all PSG_A=0xC0, B=0x10, C=0, PAN_MODE=0, SAMPLE_STB:
//    OUT_VALID at t+3, CHANNEL_L=0x1FE+0x20=0x21E, CHANNEL_R=0x020.
//  - fm_ena=1, both FM_SND=16'h8000, PSG zero:
//    CHANNEL_L=CHANNEL_R=12'hC00 (2 x 0xE00 wraps).
//  - RESET at ACC cycle 1: no OUT_VALID; CHANNEL_L/R=0. A SAMPLE_STB during ACC is ignored.

Source files
------------

// File: rtl/turbosound_pkg.sv
// Shared constants and enums for the N-chip Turbosound controller.
package turbosound_pkg;

    localparam logic [4:0] CTL_SEL  = 5'b11111;
    localparam logic [4:0] CTL_PAGE = 5'b11110;

    typedef enum logic [1:0] {
        PAN_ABC  = 2'd0,
        PAN_ACB  = 2'd1,
        PAN_MONO = 2'd2
    } pan_mode_e;

    typedef enum logic [1:0] {
        MIX_IDLE = 2'd0,
        MIX_ACC  = 2'd1,
        MIX_OUT  = 2'd2
    } mix_state_e;

endpackage

// File: rtl/ts_bus_decode.sv
// AY-style bus front end: synchronisers, control/page decode, chip strobes and read-data mux.
module ts_bus_decode
    import turbosound_pkg::*;
#(
    parameter int NUM_CHIPS = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BDIR,
    input  logic                   BC,
    input  logic [7:0]             DI,
    input  logic [8*NUM_CHIPS-1:0] CHIP_DOUT,
    output logic                   RESET_s,
    output logic                   fm_ena,
    output logic [7:0]             DO,
    output logic [7:0]             CHIP_DIN,
    output logic                   CHIP_ADDR,
    output logic [NUM_CHIPS-1:0]   CHIP_CS_N,
    output logic                   CHIP_WR_N
);

    localparam logic [2:0] SEL_RST = (NUM_CHIPS == 1) ? 3'd0 : 3'd1;
    localparam logic [3:0] NCH     = 4'(NUM_CHIPS);

    logic       rst_m;
    logic       bdir_m, bdir_s, bdir_q;
    logic       bc_m, bc_s;
    logic [7:0] di_m, di_s;
    logic [2:0] sel;
    logic       stat_sel;
    logic       acc;
    logic       wr;
    logic [7:0] din;
    logic       bdir_rise;
    logic [7:0] dout_arr [8];

    // Reset asserts immediately and releases two clocks later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rst_m   <= 1'b1;
            RESET_s <= 1'b1;
        end else begin
            rst_m   <= 1'b0;
            RESET_s <= rst_m;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bdir_m <= 1'b0;
            bdir_s <= 1'b0;
            bc_m   <= 1'b0;
            bc_s   <= 1'b0;
            di_m   <= 8'h00;
            di_s   <= 8'h00;
        end else begin
            bdir_m <= BDIR;
            bdir_s <= bdir_m;
            bc_m   <= BC;
            bc_s   <= bc_m;
            di_m   <= DI;
            di_s   <= di_m;
        end
    end

    assign bdir_rise = bdir_s & ~bdir_q;

    // acc remembers whether the current register address is writable, so the data phase can reuse it.
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            bdir_q   <= 1'b0;
            sel      <= SEL_RST;
            stat_sel <= 1'b1;
            fm_ena   <= 1'b0;
            acc      <= 1'b0;
            wr       <= 1'b0;
            din      <= 8'h00;
        end else begin
            bdir_q <= bdir_s;
            wr     <= 1'b0;
            if (bdir_rise) begin
                din <= di_s;
                if (bc_s) begin
                    if (di_s[7:3] == CTL_SEL) begin
                        sel[0]   <= di_s[0];
                        stat_sel <= di_s[1];
                        fm_ena   <= ~di_s[2];
                        acc      <= 1'b0;
                    end else if (di_s[7:3] == CTL_PAGE) begin
                        sel[2:1] <= di_s[1:0];
                        acc      <= 1'b0;
                    end else begin
                        acc <= (di_s[7:4] == 4'd0) | fm_ena;
                        wr  <= (di_s[7:4] == 4'd0) | fm_ena;
                    end
                end else begin
                    wr <= acc;
                end
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_dout
        if (g < NUM_CHIPS) begin : g_used
            assign dout_arr[g] = CHIP_DOUT[g*8 +: 8];
        end else begin : g_pad
            assign dout_arr[g] = 8'hFF;
        end
    end

    for (genvar g = 0; g < NUM_CHIPS; g++) begin : g_cs
        assign CHIP_CS_N[g] = (sel != 3'(g));
    end

    assign DO        = ({1'b0, sel} < NCH) ? dout_arr[sel] : 8'hFF;
    assign CHIP_DIN  = din;
    assign CHIP_WR_N = ~wr;
    assign CHIP_ADDR = (bdir_s | wr) ? ~bc_s : stat_sel;

endmodule

// File: rtl/turbosound_n.sv
// N-chip Turbosound controller: bus front end plus a one-chip-per-cycle PSG/FM stereo mixer.
module turbosound_n
    import turbosound_pkg::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int PSG_W     = 8,
    parameter int FM_W      = 16,
    parameter int OUT_W     = 12,
    parameter int PAN_MODE  = 0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       BDIR,
    input  logic                       BC,
    input  logic [7:0]                 DI,
    output logic [7:0]                 DO,
    output logic [7:0]                 CHIP_DIN,
    output logic                       CHIP_ADDR,
    output logic [NUM_CHIPS-1:0]       CHIP_CS_N,
    output logic                       CHIP_WR_N,
    input  logic [8*NUM_CHIPS-1:0]     CHIP_DOUT,
    input  logic [PSG_W*NUM_CHIPS-1:0] PSG_A,
    input  logic [PSG_W*NUM_CHIPS-1:0] PSG_B,
    input  logic [PSG_W*NUM_CHIPS-1:0] PSG_C,
    input  logic [FM_W*NUM_CHIPS-1:0]  FM_SND,
    input  logic                       SAMPLE_STB,
    output logic [OUT_W-1:0]           CHANNEL_L,
    output logic [OUT_W-1:0]           CHANNEL_R,
    output logic                       OUT_VALID,
    output mix_state_e                 MIX_STATE
);

    localparam int        SW   = PSG_W + 3;
    localparam int        PW   = PSG_W + 2;
    localparam int        FW   = OUT_W - 2;
    localparam logic [2:0] LAST = 3'(NUM_CHIPS - 1);
    localparam pan_mode_e PAN  = pan_mode_e'(PAN_MODE);

    logic             RESET_s;
    logic             fm_ena;
    logic             unused_fm;
    mix_state_e       state;
    logic [2:0]       idx;
    logic [SW-1:0]    sum_a, sum_b, sum_c;
    logic [OUT_W-1:0] sum_fm;
    logic [PSG_W-1:0] a_arr [8];
    logic [PSG_W-1:0] b_arr [8];
    logic [PSG_W-1:0] c_arr [8];
    logic [FW-1:0]    f_arr [8];
    logic [PW-1:0]    za, zb, zc, pan_l, pan_r;
    logic [OUT_W-1:0] mix_l, mix_r;

    ts_bus_decode #(.NUM_CHIPS(NUM_CHIPS)) u_bus (
        .CLK       (CLK),
        .RESET     (RESET),
        .BDIR      (BDIR),
        .BC        (BC),
        .DI        (DI),
        .CHIP_DOUT (CHIP_DOUT),
        .RESET_s   (RESET_s),
        .fm_ena    (fm_ena),
        .DO        (DO),
        .CHIP_DIN  (CHIP_DIN),
        .CHIP_ADDR (CHIP_ADDR),
        .CHIP_CS_N (CHIP_CS_N),
        .CHIP_WR_N (CHIP_WR_N)
    );

    for (genvar g = 0; g < 8; g++) begin : g_chip
        if (g < NUM_CHIPS) begin : g_used
            assign a_arr[g] = PSG_A[g*PSG_W +: PSG_W];
            assign b_arr[g] = PSG_B[g*PSG_W +: PSG_W];
            assign c_arr[g] = PSG_C[g*PSG_W +: PSG_W];
            assign f_arr[g] = FM_SND[g*FM_W + FM_W - 1 -: FW];
        end else begin : g_pad
            assign a_arr[g] = '0;
            assign b_arr[g] = '0;
            assign c_arr[g] = '0;
            assign f_arr[g] = '0;
        end
    end

    // Only the top FW bits of each FM sample reach the mix.
    assign unused_fm = ^FM_SND;

    always_comb begin
        za    = (|sum_a[SW-1:PSG_W]) ? PW'({PSG_W{1'b1}}) : PW'(sum_a[PSG_W-1:0]);
        zb    = (|sum_b[SW-1:PSG_W]) ? PW'({PSG_W{1'b1}}) : PW'(sum_b[PSG_W-1:0]);
        zc    = (|sum_c[SW-1:PSG_W]) ? PW'({PSG_W{1'b1}}) : PW'(sum_c[PSG_W-1:0]);
        pan_l = (za << 1) + zb;
        pan_r = (zc << 1) + zb;
        case (PAN)
            PAN_ACB: begin
                pan_l = (za << 1) + zc;
                pan_r = (zb << 1) + zc;
            end
            PAN_MONO: begin
                pan_l = za + zb + zc;
                pan_r = za + zb + zc;
            end
            default: ;
        endcase
        mix_l = OUT_W'(pan_l) + (fm_ena ? sum_fm : '0);
        mix_r = OUT_W'(pan_r) + (fm_ena ? sum_fm : '0);
    end

    // SAMPLE_STB is a request taken only in IDLE (no back-pressure, never queued);
    // OUT_VALID is a single-cycle qualifier for the freshly registered CHANNEL_L/R.
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            state     <= MIX_IDLE;
            idx       <= 3'd0;
            sum_a     <= '0;
            sum_b     <= '0;
            sum_c     <= '0;
            sum_fm    <= '0;
            CHANNEL_L <= '0;
            CHANNEL_R <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            case (state)
                MIX_IDLE: begin
                    if (SAMPLE_STB) begin
                        sum_a  <= '0;
                        sum_b  <= '0;
                        sum_c  <= '0;
                        sum_fm <= '0;
                        idx    <= 3'd0;
                        state  <= MIX_ACC;
                    end
                end
                MIX_ACC: begin
                    sum_a  <= sum_a + SW'(a_arr[idx]);
                    sum_b  <= sum_b + SW'(b_arr[idx]);
                    sum_c  <= sum_c + SW'(c_arr[idx]);
                    sum_fm <= sum_fm + {{2{f_arr[idx][FW-1]}}, f_arr[idx]};
                    idx    <= idx + 3'd1;
                    if (idx == LAST) state <= MIX_OUT;
                end
                MIX_OUT: begin
                    CHANNEL_L <= mix_l;
                    CHANNEL_R <= mix_r;
                    OUT_VALID <= 1'b1;
                    state     <= MIX_IDLE;
                end
                default: state <= MIX_IDLE;
            endcase
        end
    end

    assign MIX_STATE = state;

endmodule

// File: tb/tb_turbosound_n.sv
// Self-checking bench for turbosound_n: bus transactions and mix passes against a behavioural model.
module tb_turbosound_n;
    import turbosound_pkg::*;

    localparam int NCH   = 3;
    localparam int PSG_W = 8;
    localparam int FM_W  = 16;
    localparam int OUT_W = 12;
    localparam int PAN   = 0;

    logic                 CLK = 1'b0;
    logic                 RESET, BDIR, BC, SAMPLE_STB;
    logic [7:0]           DI, DO, CHIP_DIN;
    logic                 CHIP_ADDR, CHIP_WR_N, OUT_VALID;
    logic [NCH-1:0]       CHIP_CS_N;
    logic [8*NCH-1:0]     CHIP_DOUT;
    logic [PSG_W*NCH-1:0] PSG_A, PSG_B, PSG_C;
    logic [FM_W*NCH-1:0]  FM_SND;
    logic [OUT_W-1:0]     CHANNEL_L, CHANNEL_R;
    mix_state_e           MIX_STATE;

    // clock / reset
    always #5 CLK = ~CLK;

    turbosound_n #(
        .NUM_CHIPS (NCH),
        .PSG_W     (PSG_W),
        .FM_W      (FM_W),
        .OUT_W     (OUT_W),
        .PAN_MODE  (PAN)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BDIR       (BDIR),
        .BC         (BC),
        .DI         (DI),
        .DO         (DO),
        .CHIP_DIN   (CHIP_DIN),
        .CHIP_ADDR  (CHIP_ADDR),
        .CHIP_CS_N  (CHIP_CS_N),
        .CHIP_WR_N  (CHIP_WR_N),
        .CHIP_DOUT  (CHIP_DOUT),
        .PSG_A      (PSG_A),
        .PSG_B      (PSG_B),
        .PSG_C      (PSG_C),
        .FM_SND     (FM_SND),
        .SAMPLE_STB (SAMPLE_STB),
        .CHANNEL_L  (CHANNEL_L),
        .CHANNEL_R  (CHANNEL_R),
        .OUT_VALID  (OUT_VALID),
        .MIX_STATE  (MIX_STATE)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [2*OUT_W-1:0] exp_q[$];

    logic [7:0]       dout_b [NCH];
    logic [PSG_W-1:0] pa [NCH];
    logic [PSG_W-1:0] pb [NCH];
    logic [PSG_W-1:0] pc [NCH];
    logic [FM_W-1:0]  fm [NCH];

    logic [2:0] m_sel;
    logic       m_stat, m_fm, m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: bus decode state
    task automatic model_reset();
        m_sel  = (NCH == 1) ? 3'd0 : 3'd1;
        m_stat = 1'b1;
        m_fm   = 1'b0;
        m_acc  = 1'b0;
    endtask

    task automatic model_write(input logic bc, input logic [7:0] d, output logic pulse);
        pulse = 1'b0;
        if (bc) begin
            if (d[7:3] == 5'b11111) begin
                m_sel[0] = d[0];
                m_stat   = d[1];
                m_fm     = ~d[2];
                m_acc    = 1'b0;
            end else if (d[7:3] == 5'b11110) begin
                m_sel[2:1] = d[1:0];
                m_acc      = 1'b0;
            end else begin
                m_acc = (d[7:4] == 4'd0) || m_fm;
                pulse = m_acc;
            end
        end else begin
            pulse = m_acc;
        end
    endtask

    function automatic logic [NCH-1:0] exp_cs();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (int'(m_sel) != i);
        return v;
    endfunction

    function automatic logic [7:0] exp_do();
        if (int'(m_sel) < NCH) return dout_b[m_sel];
        return 8'hFF;
    endfunction

    // reference model: one mix pass with plain integer arithmetic
    task automatic model_mix(output logic [OUT_W-1:0] el, output logic [OUT_W-1:0] er);
        int sa = 0, sb = 0, sc = 0, fs = 0, pl, pr, smax;
        smax = (1 << PSG_W) - 1;
        for (int i = 0; i < NCH; i++) begin
            sa += int'(pa[i]);
            sb += int'(pb[i]);
            sc += int'(pc[i]);
            fs += int'($signed(fm[i])) >>> (FM_W - OUT_W + 2);
        end
        if (sa > smax) sa = smax;
        if (sb > smax) sb = smax;
        if (sc > smax) sc = smax;
        case (PAN)
            0: begin pl = 2*sa + sb; pr = 2*sc + sb; end
            1: begin pl = 2*sa + sc; pr = 2*sb + sc; end
            default: begin pl = sa + sb + sc; pr = pl; end
        endcase
        if (m_fm) begin
            pl += fs;
            pr += fs;
        end
        el = OUT_W'(pl);
        er = OUT_W'(pr);
    endtask

    // driver tasks
    task automatic drive_mix_inputs();
        for (int i = 0; i < NCH; i++) begin
            PSG_A[i*PSG_W +: PSG_W] = pa[i];
            PSG_B[i*PSG_W +: PSG_W] = pb[i];
            PSG_C[i*PSG_W +: PSG_W] = pc[i];
            FM_SND[i*FM_W +: FM_W]  = fm[i];
        end
    endtask

    task automatic set_all(input logic [PSG_W-1:0] a, input logic [PSG_W-1:0] b,
                           input logic [PSG_W-1:0] c, input logic [FM_W-1:0] f);
        for (int i = 0; i < NCH; i++) begin
            pa[i] = a; pb[i] = b; pc[i] = c; fm[i] = f;
        end
        drive_mix_inputs();
    endtask

    task automatic set_random();
        for (int i = 0; i < NCH; i++) begin
            pa[i] = PSG_W'($urandom_range(0, 255));
            pb[i] = PSG_W'($urandom_range(0, 90));
            pc[i] = PSG_W'($urandom_range(0, 255));
            fm[i] = FM_W'($urandom);
        end
        drive_mix_inputs();
    endtask

    task automatic bus_write(input logic bc, input logic [7:0] d);
        logic       exp_pulse, exp_addr, addr_at;
        logic [7:0] din_at;
        int         pulses;
        model_write(bc, d, exp_pulse);
        exp_addr = ~bc;
        pulses   = 0;
        addr_at  = 1'b0;
        din_at   = 8'h00;
        @(negedge CLK);
        BC   = bc;
        DI   = d;
        BDIR = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (CHIP_WR_N == 1'b0) begin
                pulses++;
                addr_at = CHIP_ADDR;
                din_at  = CHIP_DIN;
            end
            if (i == 5) BDIR = 1'b0;
        end
        check("wr_pulses", pulses, 32'(exp_pulse));
        if (exp_pulse && pulses == 1) begin
            check("wr_addr", addr_at, 32'(exp_addr));
            check("wr_din", din_at, d);
        end
        check("cs_n", CHIP_CS_N, exp_cs());
        check("do", DO, exp_do());
        check("addr_idle", CHIP_ADDR, 32'(m_stat));
        check("din_latched", CHIP_DIN, d);
    endtask

    task automatic mix_pass(input logic poke_extra);
        logic [OUT_W-1:0] el, er;
        int lat;
        model_mix(el, er);
        exp_q.push_back({el, er});
        @(negedge CLK);
        SAMPLE_STB = 1'b1;
        lat = -1;
        for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
            @(posedge CLK);
            #1;
            if (cyc == 1) SAMPLE_STB = 1'b0;
            if (poke_extra && cyc == 2) SAMPLE_STB = 1'b1;
            if (poke_extra && cyc == 3) SAMPLE_STB = 1'b0;
            if (OUT_VALID) lat = cyc - 1;
        end
        SAMPLE_STB = 1'b0;
        check("mix_latency", lat, NCH + 1);
        repeat (NCH + 4) @(negedge CLK);
    endtask

    // scoreboard: every OUT_VALID must match the oldest expected sample
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(OUT_VALID), 32'd0);
            end else begin
                check("mix_lr", {CHANNEL_L, CHANNEL_R}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; BDIR = 1'b0; BC = 1'b0; DI = 8'h00; SAMPLE_STB = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            dout_b[i] = 8'($urandom_range(0, 255));
            CHIP_DOUT[i*8 +: 8] = dout_b[i];
        end
        set_random();
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_l_hold", CHANNEL_L, 0);
        check("rst_valid_hold", OUT_VALID, 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        check("rst_wr_n", CHIP_WR_N, 1);
        check("rst_cs_n", CHIP_CS_N, exp_cs());
        check("rst_addr", CHIP_ADDR, 32'(m_stat));
        check("rst_din", CHIP_DIN, 0);
        check("rst_do", DO, exp_do());
        check("rst_ch", {CHANNEL_L, CHANNEL_R}, 0);
        check("rst_state", MIX_STATE, MIX_IDLE);

        // register select then data write to chip 1
        bus_write(1'b1, 8'h07);
        bus_write(1'b0, 8'h55);
        // page then select: chip 2
        bus_write(1'b1, 8'hF1);
        bus_write(1'b1, 8'hFE);
        // FM register space blocked while fm_ena is off
        bus_write(1'b1, 8'h30);
        bus_write(1'b0, 8'hAA);
        // select beyond the last chip
        bus_write(1'b1, 8'hF1);
        bus_write(1'b1, 8'hFF);
        bus_write(1'b1, 8'hF0);
        // enable FM, FM register now writable
        bus_write(1'b1, 8'hFB);
        bus_write(1'b1, 8'h30);
        bus_write(1'b0, 8'h12);

        // PSG only, stat_sel cleared, fm disabled
        bus_write(1'b1, 8'hFD);
        set_all(8'hC0, 8'h10, 8'h00, 16'h0000);
        mix_pass(1'b0);
        // FM only, most negative samples wrap
        bus_write(1'b1, 8'hFB);
        set_all(8'h00, 8'h00, 8'h00, 16'h8000);
        mix_pass(1'b0);
        // full-scale PSG with FM disabled
        set_all(8'hFF, 8'hFF, 8'hFF, 16'h7FFF);
        bus_write(1'b1, 8'hFF);
        mix_pass(1'b0);
        // extra strobe while accumulating must be dropped
        set_random();
        mix_pass(1'b1);

        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 2; w++) begin
                case ($urandom_range(0, 3))
                    0: bus_write(1'b1, {5'b11111, 3'($urandom_range(0, 7))});
                    1: bus_write(1'b1, {5'b11110, 3'($urandom_range(0, 7))});
                    2: bus_write(1'b1, 8'($urandom_range(0, 255)));
                    default: bus_write(1'b0, 8'($urandom_range(0, 255)));
                endcase
            end
            set_random();
            mix_pass(1'($urandom_range(0, 1)));
        end

        // reset during the first accumulate cycle
        set_random();
        @(negedge CLK);
        SAMPLE_STB = 1'b1;
        @(posedge CLK);
        #1 SAMPLE_STB = 1'b0;
        @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (8) @(negedge CLK);
        check("midrst_l", CHANNEL_L, 0);
        check("midrst_r", CHANNEL_R, 0);
        check("midrst_state", MIX_STATE, MIX_IDLE);
        check("midrst_cs_n", CHIP_CS_N, exp_cs());

        repeat (4) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
